// File: rtl/relu_pool_unit_if.sv
// Stream bundle for relu_pool_unit: accumulator samples in, pooled samples out.
interface relu_pool_unit_if #(
  parameter int ACC_W = 20,
  parameter int OUT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [ACC_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;

  // upstream MAC / downstream writer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // pooling unit side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/relu_pool_unit.sv
// ReLU + max/average pooling over POOL_SIZE consecutive samples, followed by
// an arithmetic shift and saturation to OUT_W. One result register with a
// simple stall: while a result is waiting, no samples are taken.
module relu_pool_unit #(
  parameter int ACC_W     = 20,
  parameter int OUT_W     = 8,
  parameter int POOL_SIZE = 4,
  parameter int SHIFT     = 0,
  parameter int GCNT_W    = 12
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic              relu_en,
  input  logic              pool_mode,
  relu_pool_unit_if.slave   bus,
  output logic              sat_flag,
  output logic [GCNT_W-1:0] group_count
);

  localparam int LOG2P = $clog2(POOL_SIZE);
  localparam int SUM_W = ACC_W + LOG2P;
  localparam logic [LOG2P-1:0]        IDX_LAST = LOG2P'(POOL_SIZE - 1);
  localparam logic [LOG2P-1:0]        IDX_ONE  = LOG2P'(1);
  localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN  = SUM_W'(-(2 ** (OUT_W - 1)));

  logic [LOG2P-1:0]        idx;
  logic signed [SUM_W-1:0] acc;
  logic signed [SUM_W-1:0] x_ext;
  logic signed [SUM_W-1:0] acc_next;
  logic signed [SUM_W-1:0] red;
  logic signed [SUM_W-1:0] q;
  logic signed [OUT_W-1:0] q_sat;
  logic signed [OUT_W-1:0] out_data_q;
  logic                    out_valid_q;
  logic                    clip;
  logic                    accept;
  logic                    handoff;
  logic                    last;

  // start forces in_ready low so a sample in the start cycle is never counted
  assign bus.in_ready  = !start && !(out_valid_q && !bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign handoff = out_valid_q && bus.out_ready;
  assign last    = (idx == IDX_LAST);

  // ReLU, reduction step, then pooled result with shift and saturation
  always_comb begin
    x_ext = {{LOG2P{bus.in_data[ACC_W-1]}}, bus.in_data};
    if (relu_en && bus.in_data[ACC_W-1]) begin
      x_ext = '0;
    end

    acc_next = x_ext;
    if (idx != '0) begin
      if (pool_mode) begin
        acc_next = acc + x_ext;
      end else if (x_ext < acc) begin
        acc_next = acc;
      end
    end

    red = pool_mode ? (acc_next >>> LOG2P) : acc_next;
    q   = red >>> SHIFT;

    clip  = 1'b0;
    q_sat = q[OUT_W-1:0];
    if (q > SAT_MAX) begin
      clip  = 1'b1;
      q_sat = SAT_MAX[OUT_W-1:0];
    end else if (q < SAT_MIN) begin
      clip  = 1'b1;
      q_sat = SAT_MIN[OUT_W-1:0];
    end
  end

  // group state, result register, sticky saturation and handoff counter
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      idx         <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_flag    <= 1'b0;
      group_count <= '0;
    end else if (start) begin
      idx         <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      sat_flag    <= 1'b0;
      group_count <= '0;
    end else begin
      if (accept) begin
        acc <= acc_next;
        idx <= last ? '0 : idx + IDX_ONE;
      end
      // a completing group wins over a handoff so out_valid stays set
      if (accept && last) begin
        out_data_q  <= q_sat;
        out_valid_q <= 1'b1;
        if (clip) begin
          sat_flag <= 1'b1;
        end
      end else if (handoff) begin
        out_valid_q <= 1'b0;
      end
      if (handoff) begin
        group_count <= group_count + GCNT_W'(1);
      end
    end
  end

endmodule

// File: doc/relu_pool_unit.md
Name: relu_pool_unit

Overview:
Parametrised successor to the fixed ReLU/2x2 max-pool stage. It sits between the convolution MAC stage and the output SRAM writer. It takes a stream of signed convolution accumulators, applies optional ReLU, and reduces each group of POOL_SIZE consecutive accepted samples by max or average. It then shifts and saturates the result to OUT_W and presents it on a valid/ready output with backpressure.

Parameters:
ACC_W, 20, width of signed input accumulator
OUT_W, 8, width of signed output sample
POOL_SIZE, 4, samples per pooling group; power of 2, >= 2
SHIFT, 0, arithmetic right shift applied before saturation (0..ACC_W-1)
GCNT_W, 12, width of completed-group counter

Ports:
clk  input  1  clock, all state on rising edge
reset_b  input  1  asynchronous, active-HIGH reset (name kept per codebase; asserted = 1)
start  input  1  one-cycle pulse: begin new layer, clears group state and counters
relu_en  input  1  1 = clamp negative samples to 0 before pooling
pool_mode  input  1  0 = max, 1 = average
in_valid  input  1  input sample valid
in_ready  output  1  unit can accept a sample this cycle
in_data  input  ACC_W  signed accumulator sample
out_valid  output  1  pooled result valid
out_ready  input  1  downstream accepts result
out_data  output  OUT_W  signed pooled, shifted, saturated result
sat_flag  output  1  sticky: a saturation occurred since start/reset
group_count  output  GCNT_W  number of results handed off (out_valid & out_ready)

Behaviour:
- Reset (reset_b=1, async): idx=0, acc=0, out_valid=0, out_data=0, sat_flag=0, group_count=0. in_ready is 1 after reset release.
- accept = in_valid & in_ready. Samples are not accepted when in_valid=0; no state changes.
- ReLU stage: x = (relu_en & in_data<0) ? 0 : in_data. relu_en and pool_mode are sampled per accepted sample. They must be held constant within a group; behaviour is undefined otherwise.
- Accumulator width: ACC_W + log2(POOL_SIZE), signed.
- Accumulate, max mode: idx==0 loads acc=x; otherwise acc=max(acc,x), signed compare.
- Accumulate, avg mode: idx==0 loads acc=x; otherwise acc=acc+x. No overflow is possible at this width.
- Index counter: idx increments on each accept and wraps to 0 after POOL_SIZE-1.
- Group completion: when accept occurs with idx==POOL_SIZE-1, compute the result combinationally from acc and x.
  - r = reduced value; in avg mode r = sum >>> log2(POOL_SIZE) (floor).
  - q = r >>> SHIFT.
  - Saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. If clipped, set sat_flag.
  - Register into out_data. out_valid=1 on the next edge.
- Latency: 1 cycle from the accepting edge of the last sample to out_valid.
- Output register holds out_data/out_valid stable until out_ready=1. On handoff, out_valid clears and group_count increments (wraps at 2^GCNT_W).
- in_ready = !(out_valid & !out_ready).
  - With out_valid=1 and out_ready=0, no new samples are accepted, including non-final ones. This is a deliberately simple stall.
- Simultaneous handoff and completion in the same cycle: out_data loads the new result and out_valid stays 1. group_count increments once.
- start: synchronous, highest priority over everything.
  - Clears idx, acc, out_valid, sat_flag and group_count.
  - Any sample presented in the same cycle is dropped; in_ready is forced to 0 that cycle.
  - A partial group in flight is discarded.
- Reset mid-operation: all state clears immediately. No output is produced for the partial group.

Test Plan:
1. Max with ReLU: relu_en=1, mode=0, SHIFT=0, stream -5,3,7,2, out_ready=1 -> one cycle after the 4th accept, out_valid=1, out_data=7, group_count=1.
2. ReLU off, all negative: relu_en=0, mode=0, stream -9,-3,-7,-4 -> out_data=-3. With relu_en=1 and the same stream -> out_data=0.
3. Average and shift: mode=1, stream 4,8,12,17 -> out_data=10 (41>>2). With SHIFT=1 the same stream -> out_data=5.
4. Saturation: mode=0, stream 300,1,2,3 -> out_data=127, sat_flag=1. Then stream -400,-500,-600,-700 with relu_en=0 -> out_data=-128, sat_flag remains 1. A start pulse -> sat_flag=0.
5. Backpressure:
   - Complete a group with out_ready=0 -> out_valid held, in_ready=0, the next sample (value 9) is not accepted, and out_data stays stable for 5 cycles.
   - Raise out_ready -> handoff, group_count +1, 9 accepted next cycle.
   - Completing a group in the same cycle as a handoff -> out_valid stays 1 with the new value.
6. Abort: accept 2 samples, pulse start with in_valid=1 -> sample dropped, idx=0. Then 4 fresh samples 1,2,3,4 (max) -> out_data=4. Repeat with async reset_b=1 pulsed mid-group -> all outputs 0 immediately.
